// File: rtl/tx_in_buffer_if.sv
// Host/transmitter-side bundle of the UART transmit input buffer.
// The host (or bench) uses the master view; the buffer itself uses the slave view.
interface tx_in_buffer_if #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AddrWidth = 3
);
  logic [DataWidth-1:0] DataIn;
  logic                 WrEn;
  logic                 DoneFlag;
  logic                 ClearOvf;
  logic [DataWidth-1:0] RegOut;
  logic                 RegValid;
  logic                 Full;
  logic                 Empty;
  logic [AddrWidth:0]   Count;
  logic                 Overflow;

  modport master (
    output DataIn, WrEn, DoneFlag, ClearOvf,
    input  RegOut, RegValid, Full, Empty, Count, Overflow
  );

  modport slave (
    input  DataIn, WrEn, DoneFlag, ClearOvf,
    output RegOut, RegValid, Full, Empty, Count, Overflow
  );
endinterface

// File: rtl/tx_in_buffer.sv
// Transmit input buffer: circular FIFO followed by a holding register that stays
// stable for a whole frame and is advanced on each rising edge of DoneFlag.
module tx_in_buffer #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AddrWidth = 3
) (
  input  logic           Clock,
  input  logic           ResetN,
  tx_in_buffer_if.slave  Bus
);

  localparam int unsigned Depth = 2 ** AddrWidth;
  localparam int unsigned CntW  = AddrWidth + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [DataWidth-1:0] mem [Depth];
  logic [AddrWidth-1:0] wrPtr;
  logic [AddrWidth-1:0] rdPtr;
  logic [CntW-1:0]      count;
  logic [CntW-1:0]      countNext;
  logic                 fullQ;
  logic                 emptyQ;
  logic                 overflowQ;
  logic                 donePrev;
  logic [DataWidth-1:0] regOutQ;
  logic                 regValidQ;

  logic adv;
  logic wrAccept;
  logic wrDrop;
  logic load;

  // Full/Empty come from registered state, so a same-cycle read never rescues a write.
  always_comb begin
    adv      = Bus.DoneFlag & ~donePrev;
    wrAccept = Bus.WrEn & ~fullQ;
    wrDrop   = Bus.WrEn & fullQ;
    load     = (~regValidQ | adv) & ~emptyQ;
  end

  always_comb begin
    countNext = count;
    unique case ({wrAccept, load})
      2'b10:   countNext = count + CntW'(1);
      2'b01:   countNext = count - CntW'(1);
      default: countNext = count;
    endcase
  end

  // Storage array carries no reset; its contents are don't-care until written.
  always_ff @(posedge Clock) begin
    if (wrAccept) begin
      mem[wrPtr] <= Bus.DataIn;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      fullQ     <= 1'b0;
      emptyQ    <= 1'b1;
      overflowQ <= 1'b0;
      donePrev  <= 1'b1;
      regOutQ   <= '0;
      regValidQ <= 1'b0;
    end else begin
      donePrev <= Bus.DoneFlag;
      count    <= countNext;
      fullQ    <= (countNext == DepthCnt);
      emptyQ   <= (countNext == '0);

      if (wrAccept) begin
        wrPtr <= wrPtr + AddrWidth'(1);
      end

      // A dropped write outranks a simultaneous clear.
      if (wrDrop) begin
        overflowQ <= 1'b1;
      end else if (Bus.ClearOvf) begin
        overflowQ <= 1'b0;
      end

      if (load) begin
        regOutQ   <= mem[rdPtr];
        regValidQ <= 1'b1;
        rdPtr     <= rdPtr + AddrWidth'(1);
      end else if (adv) begin
        regValidQ <= 1'b0;
      end
    end
  end

  assign Bus.RegOut   = regOutQ;
  assign Bus.RegValid = regValidQ;
  assign Bus.Full     = fullQ;
  assign Bus.Empty    = emptyQ;
  assign Bus.Count    = count;
  assign Bus.Overflow = overflowQ;

endmodule

// File: tb/tb_tx_in_buffer.sv
// Directed bench for tx_in_buffer: default 8-deep build plus a 4-deep build
// exercised for pointer wrap-around.
module tb_tx_in_buffer;

  logic clk;
  logic rstN;

  int totalN;
  int badN;

  // Depth-4 order monitor state
  bit          mon4;
  int          idx4;
  logic [7:0]  last4;

  tx_in_buffer_if #(.DataWidth(8), .AddrWidth(3)) bus8 ();
  tx_in_buffer_if #(.DataWidth(8), .AddrWidth(2)) bus4 ();

  tx_in_buffer #(.DataWidth(8), .AddrWidth(3)) u_dut8 (
    .Clock  (clk),
    .ResetN (rstN),
    .Bus    (bus8.slave)
  );

  tx_in_buffer #(.DataWidth(8), .AddrWidth(2)) u_dut4 (
    .Clock  (clk),
    .ResetN (rstN),
    .Bus    (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalN++;
    if (got !== exp) begin
      badN++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mon4) begin
      chk("d4_count_le_depth", 32'(bus4.Count > 3'd4), 32'd0);
      if (bus4.RegValid && (bus4.RegOut != last4)) begin
        chk($sformatf("d4_order_%0d", idx4), 32'(bus4.RegOut), 32'(8'h10 + 8'(idx4)));
        last4 = bus4.RegOut;
        idx4++;
      end
    end
  endtask

  task automatic do_reset(input logic done8, input logic done4);
    bus8.DoneFlag = done8;
    bus4.DoneFlag = done4;
    bus8.WrEn = 1'b0; bus8.ClearOvf = 1'b0; bus8.DataIn = '0;
    bus4.WrEn = 1'b0; bus4.ClearOvf = 1'b0; bus4.DataIn = '0;
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  task automatic wr8(input logic [7:0] d);
    bus8.DataIn = d;
    bus8.WrEn   = 1'b1;
    tick();
    bus8.WrEn   = 1'b0;
  endtask

  initial begin
    totalN = 0;
    badN   = 0;
    mon4   = 1'b0;
    idx4   = 0;
    last4  = 8'h00;
    rstN   = 1'b1;

    // Reset with DoneFlag already high: no spurious advance afterwards
    do_reset(1'b1, 1'b0);
    repeat (5) tick();
    chk("rst_regvalid", 32'(bus8.RegValid), 32'd0);
    chk("rst_regout",   32'(bus8.RegOut),   32'h00);
    chk("rst_count",    32'(bus8.Count),    32'd0);
    chk("rst_empty",    32'(bus8.Empty),    32'd1);
    chk("rst_full",     32'(bus8.Full),     32'd0);
    chk("rst_ovf",      32'(bus8.Overflow), 32'd0);

    // Single write: two-edge latency into the holding register
    wr8(8'hA5);
    chk("lat_count_k",    32'(bus8.Count),    32'd1);
    chk("lat_empty_k",    32'(bus8.Empty),    32'd0);
    chk("lat_valid_k",    32'(bus8.RegValid), 32'd0);
    tick();
    chk("lat_regout_k1",  32'(bus8.RegOut),   32'hA5);
    chk("lat_valid_k1",   32'(bus8.RegValid), 32'd1);
    chk("lat_count_k1",   32'(bus8.Count),    32'd0);
    chk("lat_empty_k1",   32'(bus8.Empty),    32'd1);

    // Advance with FIFO empty drops RegValid but keeps RegOut
    bus8.DoneFlag = 1'b0; tick();
    bus8.DoneFlag = 1'b1; tick();
    chk("adv_empty_valid",  32'(bus8.RegValid), 32'd0);
    chk("adv_empty_regout", 32'(bus8.RegOut),   32'hA5);

    // Fill: 9 writes -> holding register + 8 queued
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) wr8(8'(i));
    chk("fill_full",   32'(bus8.Full),   32'd1);
    chk("fill_count",  32'(bus8.Count),  32'd8);
    chk("fill_regout", 32'(bus8.RegOut), 32'h01);
    chk("fill_ovf",    32'(bus8.Overflow), 32'd0);
    wr8(8'h0A);
    chk("drop_ovf",    32'(bus8.Overflow), 32'd1);
    chk("drop_count",  32'(bus8.Count),    32'd8);
    bus8.ClearOvf = 1'b1; tick(); bus8.ClearOvf = 1'b0;
    chk("clr_ovf",     32'(bus8.Overflow), 32'd0);

    // Drain with 9 DoneFlag pulses (3 high, 2 low)
    for (int p = 1; p <= 9; p++) begin
      bus8.DoneFlag = 1'b1;
      tick();
      if (p <= 8) begin
        chk($sformatf("drain_regout_%0d", p), 32'(bus8.RegOut),   32'(p + 1));
        chk($sformatf("drain_valid_%0d", p),  32'(bus8.RegValid), 32'd1);
        chk($sformatf("drain_count_%0d", p),  32'(bus8.Count),    32'(8 - p));
      end else begin
        chk("drain_last_valid",  32'(bus8.RegValid), 32'd0);
        chk("drain_last_regout", 32'(bus8.RegOut),   32'h09);
      end
      tick(); tick();
      chk($sformatf("drain_hold_%0d", p), 32'(bus8.RegOut), 32'((p <= 8) ? p + 1 : 9));
      bus8.DoneFlag = 1'b0;
      tick(); tick();
    end
    chk("drain_empty", 32'(bus8.Empty), 32'd1);

    // Full + simultaneous write and advance: write drops, load still happens
    for (int i = 0; i < 9; i++) wr8(8'(8'hB0 + 8'(i)));
    chk("sim_pre_count",  32'(bus8.Count),  32'd8);
    chk("sim_pre_regout", 32'(bus8.RegOut), 32'hB0);
    bus8.DataIn   = 8'hCC;
    bus8.WrEn     = 1'b1;
    bus8.DoneFlag = 1'b1;
    bus8.ClearOvf = 1'b1;
    tick();
    bus8.WrEn     = 1'b0;
    bus8.ClearOvf = 1'b0;
    chk("sim_ovf",    32'(bus8.Overflow), 32'd1);
    chk("sim_regout", 32'(bus8.RegOut),   32'hB1);
    chk("sim_count",  32'(bus8.Count),    32'd7);
    chk("sim_full",   32'(bus8.Full),     32'd0);
    bus8.DoneFlag = 1'b0;
    tick();

    // Asynchronous reset mid-operation clears everything without a clock edge
    @(negedge clk);
    rstN = 1'b0;
    #2;
    chk("arst_count",  32'(bus8.Count),    32'd0);
    chk("arst_valid",  32'(bus8.RegValid), 32'd0);
    chk("arst_regout", 32'(bus8.RegOut),   32'h00);
    chk("arst_ovf",    32'(bus8.Overflow), 32'd0);
    chk("arst_empty",  32'(bus8.Empty),    32'd1);

    // Depth-4 build: 12 words through the pointers, wrapping three times
    do_reset(1'b0, 1'b0);
    mon4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus4.DataIn = 8'(8'h10 + 8'(i));
      bus4.WrEn   = 1'b1;
      tick();
    end
    bus4.WrEn = 1'b0;
    chk("d4_full",  32'(bus4.Full),  32'd1);
    chk("d4_count", 32'(bus4.Count), 32'd4);
    for (int i = 5; i < 12; i++) begin
      bus4.DoneFlag = 1'b1;
      tick();
      bus4.DoneFlag = 1'b0;
      bus4.DataIn   = 8'(8'h10 + 8'(i));
      bus4.WrEn     = 1'b1;
      tick();
      bus4.WrEn     = 1'b0;
    end
    chk("d4_ovf_none", 32'(bus4.Overflow), 32'd0);
    for (int i = 0; i < 5; i++) begin
      bus4.DoneFlag = 1'b1;
      tick();
      bus4.DoneFlag = 1'b0;
      tick();
    end
    mon4 = 1'b0;
    chk("d4_words_seen", 32'(idx4),           32'd12);
    chk("d4_final_valid", 32'(bus4.RegValid), 32'd0);
    chk("d4_final_regout", 32'(bus4.RegOut),  32'h1B);
    chk("d4_final_empty", 32'(bus4.Empty),    32'd1);

    $display("test done: total=%0d bad=%0d", totalN, badN);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tx_in_buffer.md
# tx_in_buffer

Parametrised transmit input buffer for the UART transmitter. It accepts words from the host side through a write strobe and queues them in a small FIFO. It presents one word at a time to the transmitter on a holding register that stays stable for a whole frame. The transmitter's `DoneFlag` advances the holding register. Flow status and a sticky overflow flag are reported back to the host.

## Interface
- `DataWidth`, default 8: width of a data word (5–9 legal).
- `AddrWidth`, default 3: FIFO address width; depth `Depth = 2**AddrWidth`, minimum 1 (`Depth` ≥ 2).
- `Clock`  in  1: system clock; all state changes on its rising edge.
- `ResetN`  in  1: reset, asynchronous, active-low.
- `DataIn`  in  `DataWidth`: host write data.
- `WrEn`  in  1: host write strobe, one word per cycle high.
- `DoneFlag`  in  1: transmitter frame-done level; each rising edge requests the next word.
- `ClearOvf`  in  1: synchronous clear of `Overflow`.
- `RegOut`  out  `DataWidth`: holding register driven to the transmitter.
- `RegValid`  out  1: `RegOut` holds a word not yet consumed.
- `Full`  out  1: FIFO holds `Depth` words.
- `Empty`  out  1: FIFO holds 0 words. The holding register is not counted.
- `Count`  out  `AddrWidth+1`: FIFO occupancy, 0..`Depth`.
- `Overflow`  out  1: sticky; a write was attempted while `Full`.

## Operation
- Storage: circular FIFO of `Depth` entries.
  - Write pointer and read pointer are each `AddrWidth` bits and wrap modulo `Depth`.
  - `Count` is a separate `AddrWidth+1`-bit counter.
  - Holding register `RegOut` and `RegValid` sit after the FIFO.
  - Total capacity is `Depth+1` words.
- Write:
  - Accepted when `WrEn`=1 and `Full`=0. `DataIn` is stored at the write pointer, and the pointer increments.
  - A write with `Full`=1 is dropped and sets `Overflow`. This holds even if a read happens in the same cycle: `Full` is evaluated from the registered `Count`.
- Advance detection:
  - `DonePrev` register samples `DoneFlag` every cycle; `Adv = DoneFlag & ~DonePrev`.
  - `DonePrev` resets to 1, so a `DoneFlag` already high at reset release gives no spurious advance.
- Holding-register load:
  - Load condition: (`RegValid`=0 or `Adv`=1) and FIFO not empty.
  - On load: `RegOut` ← FIFO head, read pointer increments, `RegValid`=1.
- `Adv`=1 with FIFO empty: `RegValid` ← 0, and `RegOut` retains its last value.
- `Adv` while `RegValid`=0 is ignored.
- `Count` update:
  - +1 on an accepted write only.
  - −1 on a load only.
  - Unchanged when both occur in the same cycle.
- `Full` and `Empty` are decoded from `Count`: `Full` = (`Count`==`Depth`), `Empty` = (`Count`==0).
- `Overflow`:
  - Set by a dropped write.
  - Cleared by `ClearOvf`=1.
  - If a dropped write and `ClearOvf` occur in the same cycle, set wins.
- No bypass path: a word always passes through the FIFO.

## Timing
- Reset, asynchronous: `RegOut`=0, `RegValid`=0, `Count`=0, `Empty`=1, `Full`=0, `Overflow`=0, pointers=0, `DonePrev`=1. FIFO contents are don't-care.
- Write to an idle, empty buffer at edge k:
  - `Count`=1 after edge k.
  - Load at edge k+1: `RegOut` valid, `RegValid`=1, `Count`=0.
  - Latency is 2 edges.
- Advance: `DoneFlag` rises before edge j. `RegOut` updates at edge j, the first edge that samples `DoneFlag` high.
- `DoneFlag` held high for many cycles counts as one advance.
- Back-to-back rising edges of `DoneFlag` are legal, minimum period 2 cycles; each consumes one word.
- Status outputs (`Full`, `Empty`, `Count`) are registered and reflect the state after the most recent edge.
- Reset asserted mid-operation immediately clears all queued words and status; no partial state is retained.

## Test plan
- Reset with `DoneFlag`=1, release, hold 5 cycles → `RegValid`=0, `RegOut`=0, `Count`=0, no advance.
- Write 0xA5 at edge k → `Count`=1 after k. At k+1: `RegOut`=0xA5, `RegValid`=1, `Count`=0, `Empty`=1.
- Defaults, `RegValid`=0: write 0x01..0x09 on 9 consecutive cycles.
  - First write loads the holding register; remaining 8 fill the FIFO → `Full`=1, `Count`=8, `RegOut`=0x01.
  - A 10th write of 0x0A → dropped, `Overflow`=1, `Count` stays 8.
  - `ClearOvf` → `Overflow`=0.
- From that full state, pulse `DoneFlag` 9 times, each high for 3 cycles and low for 2.
  - `RegOut` sequence: 0x02..0x09.
  - 9th pulse → `RegValid`=0 with `RegOut` held at 0x09.
  - 0x0A never appears.
- With `Count`=8 and `RegValid`=1, assert `WrEn` and a `DoneFlag` rising edge in the same cycle → write dropped, `Overflow`=1, load occurs, `Count`=7.
- Depth=4 build: write 0x10..0x1B with advances interleaved so the pointers wrap three times → `RegOut` order is exactly 0x10..0x1B, and `Count` never exceeds 4.
